// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
//   Instruction-memory read bus between the fetch unit and the memory.
//   mem_rd    : read strobe (fetch -> memory)
//   mem_addr  : 9-bit word address (fetch -> memory)
//   mem_rdata : 16-bit instruction word (memory -> fetch)
//   mem_valid : mem_rdata is valid this cycle (memory -> fetch)
// ---------------------------------------------------------------------------
interface instruction_fetch_if;
  logic        mem_rd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_valid;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata,
    input  mem_valid
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata,
    output mem_valid
  );
endinterface

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetches one instruction word per request from instruction memory, holds
//   it for a downstream consumer and tells the PC stage how to advance:
//   load_PC (increment) for ordinary instructions, imJumpFlag/imJump (load)
//   for jumps (opcode bits [15:13] = 3'b111). A memory that never answers is
//   retried three times after the first attempt, then the block parks in a
//   sticky error state until reset.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous, active-high reset
//   fetch_en     : permission to start a new fetch
//   PC_in        : current program counter
//   mem          : instruction memory bus (master side)
//   load_PC      : one-cycle PC increment pulse
//   imJumpFlag   : one-cycle PC load pulse
//   imJump       : jump target, holds its last value between pulses
//   instr_out    : captured instruction
//   instr_valid  : instr_out not yet consumed
//   instr_ready  : downstream accepts instr_out
//   fetch_err    : sticky memory-timeout error
// ---------------------------------------------------------------------------
module instruction_fetch (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  input  logic [8:0]                 PC_in,
  instruction_fetch_if.master        mem,
  output logic                       load_PC,
  output logic                       imJumpFlag,
  output logic [8:0]                 imJump,
  output logic [15:0]                instr_out,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic                       fetch_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } state_e;

  // The wait counter reaches this value on the last WAIT cycle of an attempt,
  // giving 15 WAIT cycles and a 16-cycle spacing between strobes.
  localparam logic [3:0] WAIT_LAST = 4'd15;
  localparam logic [1:0] RETRY_MAX = 2'd3;
  localparam logic [2:0] JUMP_OP   = 3'b111;

  state_e      state_q, state_d;
  logic [8:0]  addr_q, addr_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  retry_q, retry_d;
  logic        mem_rd_q, mem_rd_d;
  logic        load_pc_q, load_pc_d;
  logic        jump_flag_q, jump_flag_d;
  logic [8:0]  jump_q, jump_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [8:0]  req_addr;

  // The PC pulse is issued in the first HOLD cycle and the PC stage applies
  // it on the same edge that can enter REQ, so a first-attempt REQ must take
  // its address straight from PC_in. Retries re-issue the latched address.
  assign req_addr = (state_q == REQ && retry_q == 2'd0) ? PC_in : addr_q;

  // NOTE: every variable written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wait_cnt_d  = wait_cnt_q;
    retry_d     = retry_q;
    instr_d     = instr_q;
    jump_d      = jump_q;
    load_pc_d   = 1'b0;
    jump_flag_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetch_en) state_d = REQ;
      end

      REQ: begin
        addr_d     = req_addr;
        wait_cnt_d = 4'd0;
        state_d    = WAIT;
      end

      WAIT: begin
        // Data beats timeout: a response on the final WAIT cycle is a capture.
        if (mem.mem_valid) begin
          instr_d = mem.mem_rdata;
          retry_d = 2'd0;
          if (mem.mem_rdata[15:13] == JUMP_OP) begin
            jump_flag_d = 1'b1;
            jump_d      = mem.mem_rdata[8:0];
          end else begin
            load_pc_d = 1'b1;
          end
          state_d = HOLD;
        end else if (wait_cnt_q == WAIT_LAST - 4'd1) begin
          // Counter reaches its ceiling on this edge and stops there.
          wait_cnt_d = WAIT_LAST;
          if (retry_q == RETRY_MAX) begin
            state_d = ERR;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = REQ;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      HOLD: begin
        if (instr_ready) state_d = fetch_en ? REQ : IDLE;
      end

      ERR: begin
        state_d = ERR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state the FSM is actually in.
  assign mem_rd_d = (state_d == REQ);
  assign valid_d  = (state_d == HOLD);
  assign err_d    = err_q | (state_d == ERR);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 9'd0;
      wait_cnt_q  <= 4'd0;
      retry_q     <= 2'd0;
      mem_rd_q    <= 1'b0;
      load_pc_q   <= 1'b0;
      jump_flag_q <= 1'b0;
      jump_q      <= 9'd0;
      instr_q     <= 16'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wait_cnt_q  <= wait_cnt_d;
      retry_q     <= retry_d;
      mem_rd_q    <= mem_rd_d;
      load_pc_q   <= load_pc_d;
      jump_flag_q <= jump_flag_d;
      jump_q      <= jump_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_rd   = mem_rd_q;
  assign mem.mem_addr = req_addr;
  assign load_PC      = load_pc_q;
  assign imJumpFlag   = jump_flag_q;
  assign imJump       = jump_q;
  assign instr_out    = instr_q;
  assign instr_valid  = valid_q;
  assign fetch_err    = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch. A small PC-stage model reacts
//   to load_PC / imJumpFlag; the memory side is driven from the test tasks.
//   Expected instructions are queued when memory data is driven and popped
//   when the fetch unit presents them.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [8:0]  PC_in;
  logic        load_PC;
  logic        imJumpFlag;
  logic [8:0]  imJump;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_err;

  instruction_fetch_if mem_if ();

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .PC_in       (PC_in),
    .mem         (mem_if),
    .load_PC     (load_PC),
    .imJumpFlag  (imJumpFlag),
    .imJump      (imJump),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  // PC stage model: increments on load_PC, loads on imJumpFlag.
  logic [8:0] pc_init;
  logic [8:0] pc_q;
  always @(posedge clk or posedge reset) begin
    if (reset)           pc_q <= pc_init;
    else if (load_PC)    pc_q <= pc_q + 9'd1;
    else if (imJumpFlag) pc_q <= imJump;
  end
  assign PC_in = pc_q;

  typedef struct {
    logic [15:0] instr;
    logic        is_jump;
    logic [8:0]  target;
  } exp_t;

  exp_t       sb[$];
  int         passed = 0;
  int         total  = 0;
  logic [8:0] exp_pc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic [8:0] pc);
    pc_init = pc;
    exp_pc  = pc;
    fetch_en = 1'b0;
    instr_ready = 1'b0;
    mem_if.mem_valid = 1'b0;
    mem_if.mem_rdata = 16'h0000;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    sb.delete();
  endtask

  // One complete fetch: wait for the strobe, answer after lat WAIT cycles,
  // check the HOLD outputs, then optionally stall the consumer.
  task automatic fetch_one(input logic [15:0] data, input int lat,
                           input int stall, input logic keep_en);
    exp_t       e;
    bit         seen;
    bit         bad;
    logic [8:0] req_addr;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (mem_if.mem_rd === 1'b1) seen = 1'b1;
      else tick();
    end
    total++;
    if (!seen) begin
      $display("FAIL fetch_req: no mem_rd within 40 cycles, expected strobe at addr %h", exp_pc);
      return;
    end
    passed++;
    req_addr = exp_pc;
    total++;
    if (mem_if.mem_addr !== req_addr)
      $display("FAIL req_addr: got %h expected %h", mem_if.mem_addr, req_addr);
    else passed++;
    total++;
    if ({load_PC, imJumpFlag, instr_valid} !== 3'b000)
      $display("FAIL req_outputs: load_PC/imJumpFlag/instr_valid got %b expected 000",
               {load_PC, imJumpFlag, instr_valid});
    else passed++;

    fetch_en    = keep_en;
    instr_ready = (stall == 0);
    bad = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      tick();
      if (mem_if.mem_rd !== 1'b0 || mem_if.mem_addr !== req_addr || instr_valid !== 1'b0)
        bad = 1'b1;
      if (i == lat) begin
        mem_if.mem_valid = 1'b1;
        mem_if.mem_rdata = data;
        e.instr   = data;
        e.is_jump = (data[15:13] == 3'b111);
        e.target  = data[8:0];
        sb.push_back(e);
      end
    end
    total++;
    if (bad) $display("FAIL wait_hold: mem_rd/mem_addr/instr_valid wrong during WAIT, expected 0/%h/0", req_addr);
    else passed++;

    tick();
    mem_if.mem_valid = 1'b0;
    mem_if.mem_rdata = 16'hDEAD;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: empty when instruction presented, got %h expected an entry", instr_out);
      return;
    end
    passed++;
    e = sb.pop_front();
    total++;
    if (instr_valid !== 1'b1 || instr_out !== e.instr)
      $display("FAIL capture: valid/instr got %b/%h expected 1/%h", instr_valid, instr_out, e.instr);
    else passed++;
    total++;
    if (load_PC !== !e.is_jump || imJumpFlag !== e.is_jump)
      $display("FAIL pc_pulse: load_PC/imJumpFlag got %b%b expected %b%b",
               load_PC, imJumpFlag, !e.is_jump, e.is_jump);
    else passed++;
    if (e.is_jump) begin
      total++;
      if (imJump !== e.target) $display("FAIL imJump: got %h expected %h", imJump, e.target);
      else passed++;
    end
    exp_pc = e.is_jump ? e.target : exp_pc + 9'd1;

    // Consumer stall: stray mem_valid is driven to prove it is ignored.
    bad = 1'b0;
    for (int s = 1; s <= stall; s++) begin
      mem_if.mem_valid = 1'b1;
      mem_if.mem_rdata = ~data;
      tick();
      if (instr_valid !== 1'b1 || instr_out !== e.instr || load_PC !== 1'b0 ||
          imJumpFlag !== 1'b0 || mem_if.mem_rd !== 1'b0)
        bad = 1'b1;
      if (s == stall) begin
        instr_ready = 1'b1;
        mem_if.mem_valid = 1'b0;
      end
    end
    if (stall > 0) begin
      total++;
      if (bad) $display("FAIL stall_hold: outputs changed during stall, expected valid=1 instr=%h no pulses", e.instr);
      else passed++;
    end
  endtask

  task automatic test_reset;
    apply_reset(9'h000);
    total++;
    if ({mem_if.mem_rd, mem_if.mem_addr, load_PC, imJumpFlag, imJump, instr_out,
         instr_valid, fetch_err} !== 39'd0)
      $display("FAIL reset_state: outputs not all zero after reset, got %h expected 0",
               {mem_if.mem_rd, mem_if.mem_addr, load_PC, imJumpFlag, imJump, instr_out,
                instr_valid, fetch_err});
    else passed++;
    repeat (3) tick();
    total++;
    if (mem_if.mem_rd !== 1'b0) $display("FAIL idle_hold: mem_rd got %b expected 0", mem_if.mem_rd);
    else passed++;
  endtask

  task automatic test_basic_fetch;
    apply_reset(9'd5);
    fetch_en = 1'b1;
    fetch_one(16'h1234, 2, 0, 1'b1);
    fetch_one(16'hE0AB, 1, 0, 1'b1);
    fetch_one(16'h4321, 3, 0, 1'b1);
  endtask

  task automatic test_jump_and_wrap;
    // Continues from test_basic_fetch: PC is now 0AC.
    fetch_one(16'hC1FF, 1, 0, 1'b1);
    fetch_one(16'hFFFF, 2, 0, 1'b1);
    fetch_one(16'h0000, 1, 0, 1'b0);
    tick();
    total++;
    if (mem_if.mem_rd !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL idle_after_hold: mem_rd/instr_valid got %b/%b expected 0/0",
               mem_if.mem_rd, instr_valid);
    else passed++;
    fetch_en = 1'b1;
    fetch_one(16'h0001, 1, 0, 1'b0);
  endtask

  task automatic test_stall;
    apply_reset(9'h020);
    fetch_en = 1'b1;
    fetch_one(16'h5A5A, 1, 10, 1'b1);
    fetch_one(16'h0F0F, 1, 0, 1'b0);
  endtask

  task automatic test_timeout;
    int  strobe_cyc[$];
    bit  bad_addr;
    bit  bad_other;
    int  err_cyc;
    apply_reset(9'h077);
    fetch_en = 1'b1;
    bad_addr = 1'b0;
    bad_other = 1'b0;
    err_cyc = -1;
    for (int c = 0; c < 90; c++) begin
      if (mem_if.mem_rd === 1'b1) begin
        strobe_cyc.push_back(c);
        if (mem_if.mem_addr !== 9'h077) bad_addr = 1'b1;
      end
      if (fetch_err === 1'b1 && err_cyc < 0) err_cyc = c;
      if (instr_valid !== 1'b0 || load_PC !== 1'b0 || imJumpFlag !== 1'b0) bad_other = 1'b1;
      tick();
    end
    total++;
    if (strobe_cyc.size() != 4) $display("FAIL strobe_count: got %0d expected 4", strobe_cyc.size());
    else passed++;
    for (int i = 1; i < strobe_cyc.size(); i++) begin
      total++;
      if (strobe_cyc[i] - strobe_cyc[i-1] != 16)
        $display("FAIL strobe_gap: got %0d expected 16", strobe_cyc[i] - strobe_cyc[i-1]);
      else passed++;
    end
    total++;
    if (bad_addr) $display("FAIL retry_addr: retry strobe address differed, expected 077");
    else passed++;
    total++;
    if (err_cyc != 65) $display("FAIL err_timing: fetch_err rose at cycle %0d expected 65", err_cyc);
    else passed++;
    total++;
    if (bad_other) $display("FAIL timeout_outputs: valid or PC pulse seen, expected none");
    else passed++;
    bad_other = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mem_if.mem_valid = 1'b1;
      mem_if.mem_rdata = 16'h1234;
      tick();
      if (fetch_err !== 1'b1 || mem_if.mem_rd !== 1'b0 || instr_valid !== 1'b0 || load_PC !== 1'b0)
        bad_other = 1'b1;
    end
    mem_if.mem_valid = 1'b0;
    total++;
    if (bad_other) $display("FAIL err_sticky: ERR outputs changed, expected fetch_err=1 others 0");
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (fetch_err !== 1'b0) $display("FAIL err_reset: fetch_err got %b expected 0", fetch_err);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_late_capture;
    apply_reset(9'h0C0);
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    tick();
    total++;
    if (mem_if.mem_rd !== 1'b1) $display("FAIL late_req: mem_rd got %b expected 1", mem_if.mem_rd);
    else passed++;
    repeat (15) tick();
    tick();
    total++;
    if (mem_if.mem_rd !== 1'b1 || mem_if.mem_addr !== 9'h0C0)
      $display("FAIL reissue: mem_rd/addr got %b/%h expected 1/0c0", mem_if.mem_rd, mem_if.mem_addr);
    else passed++;
    fetch_one(16'h2222, 15, 0, 1'b1);
    total++;
    if (dut.retry_q !== 2'd0) $display("FAIL retry_clear: retry_q got %0d expected 0", dut.retry_q);
    else passed++;
    fetch_one(16'h7777, 15, 0, 1'b0);
  endtask

  task automatic test_reset_mid_wait;
    apply_reset(9'h0AA);
    fetch_en = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++;
    if ({mem_if.mem_rd, mem_if.mem_addr, load_PC, imJumpFlag, imJump, instr_out,
         instr_valid, fetch_err} !== 39'd0)
      $display("FAIL async_reset: outputs got %h expected 0 before next edge",
               {mem_if.mem_rd, mem_if.mem_addr, load_PC, imJumpFlag, imJump, instr_out,
                instr_valid, fetch_err});
    else passed++;
    fetch_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    mem_if.mem_valid = 1'b1;
    mem_if.mem_rdata = 16'h1111;
    tick();
    mem_if.mem_valid = 1'b0;
    total++;
    if ({instr_valid, load_PC, imJumpFlag, mem_if.mem_rd} !== 4'b0000 || instr_out !== 16'h0000)
      $display("FAIL late_valid: valid/pulses/rd got %b instr %h expected 0000/0000",
               {instr_valid, load_PC, imJumpFlag, mem_if.mem_rd}, instr_out);
    else passed++;
    total++;
    if (PC_in !== 9'h0AA) $display("FAIL no_pc_pulse: PC got %h expected 0aa", PC_in);
    else passed++;
    fetch_en = 1'b1;
    tick();
    total++;
    if (mem_if.mem_rd !== 1'b1 || mem_if.mem_addr !== 9'h0AA)
      $display("FAIL first_req: mem_rd/addr got %b/%h expected 1/0aa", mem_if.mem_rd, mem_if.mem_addr);
    else passed++;
    fetch_one(16'h3333, 1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_jump_and_wrap();
    test_stall();
    test_timeout();
    test_late_capture();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL have port fetch_en, input, 1, permits starting a new fetch.
REQ-004 SHALL have port PC_in, input, 9, current program counter value.
REQ-005 SHALL have port mem_rd, output, 1, instruction memory read strobe.
REQ-006 SHALL have port mem_addr, output, 9, instruction memory address.
REQ-007 SHALL have port mem_rdata, input, 16, instruction memory read data.
REQ-008 SHALL have port mem_valid, input, 1, mem_rdata is valid this cycle.
REQ-009 SHALL have port load_PC, output, 1, one-cycle PC increment pulse.
REQ-010 SHALL have port imJumpFlag, output, 1, one-cycle PC load pulse.
REQ-011 SHALL have port imJump, output, 9, jump target for the PC load.
REQ-012 SHALL have port instr_out, output, 16, captured instruction register.
REQ-013 SHALL have port instr_valid, output, 1, instr_out holds an instruction not yet consumed.
REQ-014 SHALL have port instr_ready, input, 1, downstream accepts instr_out.
REQ-015 SHALL have port fetch_err, output, 1, sticky memory-timeout error.

Function
REQ-016 SHALL implement the FSM states IDLE, REQ, WAIT, HOLD, ERR; all outputs are registered.
REQ-017 IDLE SHALL go to REQ when fetch_en=1, and remain in IDLE otherwise.
REQ-018 REQ SHALL drive mem_rd=1 and mem_addr=PC_in for exactly one cycle, latch PC_in internally, and go to WAIT.
REQ-019 mem_addr SHALL hold the latched address through WAIT; mem_rd SHALL be 0 outside REQ.
REQ-020 WAIT with mem_valid=1 SHALL capture mem_rdata into instr_out and go to HOLD.
REQ-021 mem_valid outside WAIT SHALL be ignored; instr_out SHALL be unchanged by it.
REQ-022 On capture, if mem_rdata[15:13]=3'b111 (jump), imJumpFlag=1 and imJump=mem_rdata[8:0] SHALL be driven during the first HOLD cycle.
REQ-023 On capture of any non-jump instruction, load_PC=1 SHALL be driven during the first HOLD cycle.
REQ-024 load_PC and imJumpFlag SHALL never both be 1; each pulse SHALL last exactly one cycle per fetched instruction.
REQ-025 imJump SHALL hold its last value when imJumpFlag=0.
REQ-026 instr_valid SHALL be 1 in every HOLD cycle and 0 in every other state.
REQ-027 HOLD with instr_ready=1 SHALL go to REQ if fetch_en=1, and to IDLE otherwise.
REQ-028 HOLD with instr_ready=0 SHALL remain in HOLD with instr_out stable.
REQ-029 Because the PC update pulse occurs in the first HOLD cycle, the next REQ (earliest one cycle later) SHALL present the updated PC_in.
REQ-030 A 4-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle with mem_valid=0.
REQ-031 When the wait counter reaches 15, the FSM SHALL return to REQ (re-issue same address) and increment a 2-bit retry counter.
REQ-032 The retry counter SHALL clear on each successful capture.
REQ-033 A timeout with retry counter=3 SHALL go to ERR; ERR SHALL set fetch_err=1 and hold mem_rd, load_PC, imJumpFlag and instr_valid at 0 until reset.
REQ-034 mem_valid=1 in the same cycle the wait counter reaches 15 SHALL count as a successful capture, not a timeout.
REQ-035 Deasserting fetch_en in REQ or WAIT SHALL NOT abort the outstanding fetch; it takes effect only at the HOLD exit.
REQ-036 Counter arithmetic SHALL saturate at state transitions and never wrap silently; PC wrap 511->0 is the PC stage's concern, and this block passes PC_in through unmodified.

Reset
REQ-037 Assertion of reset SHALL immediately force state=IDLE.
REQ-038 Assertion of reset SHALL immediately clear mem_rd, load_PC, imJumpFlag, instr_valid and fetch_err to 0.
REQ-039 Assertion of reset SHALL immediately clear mem_addr, imJump, instr_out and both counters to 0.
REQ-040 Reset asserted mid-fetch (REQ, WAIT or HOLD) SHALL discard the fetch with no PC pulse issued, and any late mem_valid SHALL be ignored.
REQ-041 After reset deasserts, the first REQ SHALL occur on the first clk edge with fetch_en=1.

Verification
REQ-042 Scenario: PC_in=5, mem_rdata=16'h1234, mem_valid 2 cycles after mem_rd, instr_ready=1 -> mem_addr=5, instr_out=16'h1234, one load_PC pulse, next mem_addr=6.
REQ-043 Scenario: fetch of 16'hE0AB -> imJumpFlag pulse with imJump=9'h0AB, load_PC=0, next REQ address=9'h0AB.
REQ-044 Scenario: instr_ready held 0 for 10 cycles -> instr_valid=1 and instr_out stable throughout, exactly one PC pulse, no new mem_rd.
REQ-045 Scenario: mem_valid never asserted -> 4 mem_rd strobes to the same address, each 16 cycles apart, then fetch_err=1 and mem_rd=0 permanently.
REQ-046 Scenario: reset asserted asynchronously mid-WAIT -> all outputs 0 before the next clk edge, and a mem_valid 1 cycle after reset release is ignored.
REQ-047 Scenario: mem_valid on the 15th WAIT cycle -> capture succeeds, retry counter=0, no re-issue.
